// File: rtl/sdio_cmd_arbiter_if.sv
// Bundle of requester, response, transmitter and receiver signals around
// the SDIO command arbiter. The arbiter is the slave; the requesters and
// the command PHY together form the master side.
interface sdio_cmd_arbiter_if;
  logic         req0_valid;
  logic [5:0]   req0_cmd;
  logic [31:0]  req0_para;
  logic [1:0]   req0_rsp;
  logic         req0_ack;
  logic         req0_done;

  logic         req1_valid;
  logic [5:0]   req1_cmd;
  logic [31:0]  req1_para;
  logic [1:0]   req1_rsp;
  logic         req1_ack;
  logic         req1_done;

  logic [1:0]   rsp_status;
  logic [5:0]   rsp_cmd;
  logic [31:0]  rsp_para;
  logic [119:0] rsp_cid;
  logic         busy;

  logic         o_tx_en;
  logic [5:0]   o_tx_cmd;
  logic [31:0]  o_tx_para;
  logic         i_tx_busy;

  logic         o_rx_listen;
  logic         o_rx_rsp136en;
  logic         i_rx_de;
  logic         i_rx_crc7_down;
  logic [5:0]   i_rx_cmd;
  logic [31:0]  i_rx_para;
  logic [119:0] i_rx_cid;

  modport slave (
    input  req0_valid, req0_cmd, req0_para, req0_rsp,
    input  req1_valid, req1_cmd, req1_para, req1_rsp,
    output req0_ack, req0_done, req1_ack, req1_done,
    output rsp_status, rsp_cmd, rsp_para, rsp_cid, busy,
    output o_tx_en, o_tx_cmd, o_tx_para,
    input  i_tx_busy,
    output o_rx_listen, o_rx_rsp136en,
    input  i_rx_de, i_rx_crc7_down, i_rx_cmd, i_rx_para, i_rx_cid
  );

  modport master (
    output req0_valid, req0_cmd, req0_para, req0_rsp,
    output req1_valid, req1_cmd, req1_para, req1_rsp,
    input  req0_ack, req0_done, req1_ack, req1_done,
    input  rsp_status, rsp_cmd, rsp_para, rsp_cid, busy,
    input  o_tx_en, o_tx_cmd, o_tx_para,
    output i_tx_busy,
    input  o_rx_listen, o_rx_rsp136en,
    output i_rx_de, i_rx_crc7_down, i_rx_cmd, i_rx_para, i_rx_cid
  );
endinterface

// File: rtl/sdio_cmd_arbiter.sv
// Two-requester round-robin arbiter for the SDIO command line. Issues the
// granted command to the transmitter, waits for it to drain, optionally
// listens for a response (with timeout) and reports a status per command.
module sdio_cmd_arbiter #(
  parameter int TX_SETTLE   = 10,
  parameter int RSP_TIMEOUT = 100
) (
  input logic               ctrl_clk,
  input logic               rst_n,
  sdio_cmd_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, TX_WAIT, RX_WAIT, DONE} state_t;

  localparam logic [1:0]  ST_OK       = 2'd0;
  localparam logic [1:0]  ST_TIMEOUT  = 2'd1;
  localparam logic [1:0]  ST_CRC      = 2'd2;
  localparam logic [1:0]  ST_INDEX    = 2'd3;
  localparam logic [31:0] SETTLE_CNT  = 32'(TX_SETTLE);
  localparam logic [31:0] TIMEOUT_CNT = 32'(RSP_TIMEOUT);

  state_t        state_reg;
  logic [31:0]   cnt_reg;
  logic          last_grant_reg;
  logic          grantee_reg;
  logic [1:0]    rsp_type_reg;
  logic [5:0]    tx_cmd_reg;
  logic [31:0]   tx_para_reg;
  logic          tx_en_reg;
  logic          listen_reg;
  logic          rsp136en_reg;
  logic          done0_reg;
  logic          done1_reg;
  logic [1:0]    status_reg;
  logic [5:0]    rsp_cmd_reg;
  logic [31:0]   rsp_para_reg;
  logic [119:0]  rsp_cid_reg;

  logic          grant_any;
  logic          grant_sel;
  logic          in_idle;
  logic [1:0]    rx_status;

  // Pick a winner: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_sel = ~last_grant_reg;
    else                                  grant_sel = bus.req1_valid;
  end

  // The ack is decided and shown in the grant cycle itself, so it is
  // combinational; rst_n gates it so it stays low while reset is held.
  assign in_idle      = rst_n && (state_reg == IDLE);
  assign bus.req0_ack = in_idle && grant_any && !grant_sel;
  assign bus.req1_ack = in_idle && grant_any && grant_sel;

  // Classify a received response; the latched command is still held in tx_cmd_reg.
  always_comb begin
    rx_status = ST_OK;
    case (rsp_type_reg)
      2'd1: begin
        if (!bus.i_rx_crc7_down)                rx_status = ST_CRC;
        else if (bus.i_rx_cmd != tx_cmd_reg)    rx_status = ST_INDEX;
      end
      2'd2: begin
        if (!bus.i_rx_crc7_down)                rx_status = ST_CRC;
      end
      default: rx_status = ST_OK;
    endcase
  end

  // Command sequencing FSM with registered outputs and asynchronous reset.
  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      grantee_reg    <= 1'b0;
      rsp_type_reg   <= '0;
      tx_cmd_reg     <= '0;
      tx_para_reg    <= '0;
      tx_en_reg      <= 1'b0;
      listen_reg     <= 1'b0;
      rsp136en_reg   <= 1'b0;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
      status_reg     <= '0;
      rsp_cmd_reg    <= '0;
      rsp_para_reg   <= '0;
      rsp_cid_reg    <= '0;
    end else begin
      tx_en_reg <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            tx_cmd_reg     <= grant_sel ? bus.req1_cmd  : bus.req0_cmd;
            tx_para_reg    <= grant_sel ? bus.req1_para : bus.req0_para;
            rsp_type_reg   <= grant_sel ? bus.req1_rsp  : bus.req0_rsp;
            grantee_reg    <= grant_sel;
            last_grant_reg <= grant_sel;
            tx_en_reg      <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= TX_WAIT;
        end
        TX_WAIT: begin
          if (cnt_reg != SETTLE_CNT) begin
            cnt_reg <= cnt_reg + 32'd1;
          end else if (!bus.i_tx_busy) begin
            if (rsp_type_reg == 2'd0) begin
              status_reg <= ST_OK;
              done0_reg  <= !grantee_reg;
              done1_reg  <= grantee_reg;
              state_reg  <= DONE;
            end else begin
              listen_reg   <= 1'b1;
              rsp136en_reg <= (rsp_type_reg == 2'd2);
              cnt_reg      <= '0;
              state_reg    <= RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          // A response arriving in the timeout cycle still wins.
          if (bus.i_rx_de) begin
            rsp_cmd_reg  <= bus.i_rx_cmd;
            rsp_para_reg <= bus.i_rx_para;
            rsp_cid_reg  <= bus.i_rx_cid;
            status_reg   <= rx_status;
            listen_reg   <= 1'b0;
            rsp136en_reg <= 1'b0;
            done0_reg    <= !grantee_reg;
            done1_reg    <= grantee_reg;
            state_reg    <= DONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            status_reg   <= ST_TIMEOUT;
            listen_reg   <= 1'b0;
            rsp136en_reg <= 1'b0;
            done0_reg    <= !grantee_reg;
            done1_reg    <= grantee_reg;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_done     = done0_reg;
  assign bus.req1_done     = done1_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.o_tx_en       = tx_en_reg;
  assign bus.o_tx_cmd      = tx_cmd_reg;
  assign bus.o_tx_para     = tx_para_reg;
  assign bus.o_rx_listen   = listen_reg;
  assign bus.o_rx_rsp136en = rsp136en_reg;
  assign bus.rsp_status    = status_reg;
  assign bus.rsp_cmd       = rsp_cmd_reg;
  assign bus.rsp_para      = rsp_para_reg;
  assign bus.rsp_cid       = rsp_cid_reg;
endmodule

// File: tb/tb_sdio_cmd_arbiter.sv
// Directed, table-driven bench for sdio_cmd_arbiter. Cycle 0 of a command
// is the IDLE cycle in which the requester's valid is seen and ack is high.
module tb_sdio_cmd_arbiter;
  localparam int TS = 10;
  localparam int RT = 100;

  typedef struct {
    bit           who;
    logic [5:0]   cmd;
    logic [31:0]  para;
    logic [1:0]   rsp;
    int           busy_cyc;   // i_tx_busy high for cycles 0..busy_cyc-1
    int           de_dly;     // cycles after listen rises; -1 = no response
    logic [5:0]   rx_cmd;
    logic [31:0]  rx_para;
    logic [119:0] rx_cid;
    bit           crc;
    logic [1:0]   exp_status;
  } vec_t;

  logic ctrl_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  logic [5:0]   m_rsp_cmd  = '0;
  logic [31:0]  m_rsp_para = '0;
  logic [119:0] m_rsp_cid  = '0;

  sdio_cmd_arbiter_if bus ();

  sdio_cmd_arbiter #(.TX_SETTLE(TS), .RSP_TIMEOUT(RT)) dut (
    .ctrl_clk (ctrl_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit who, input logic [5:0] cmd, input logic [31:0] para,
                              input logic [1:0] rsp, input int busy_cyc, input int de_dly,
                              input logic [5:0] rx_cmd, input logic [31:0] rx_para,
                              input logic [119:0] rx_cid, input bit crc, input logic [1:0] exp_status);
    vec_t v;
    v.who = who; v.cmd = cmd; v.para = para; v.rsp = rsp; v.busy_cyc = busy_cyc;
    v.de_dly = de_dly; v.rx_cmd = rx_cmd; v.rx_para = rx_para; v.rx_cid = rx_cid;
    v.crc = crc; v.exp_status = exp_status;
    return v;
  endfunction

  function automatic logic get_ack(input bit who);
    return who ? bus.req1_ack : bus.req0_ack;
  endfunction

  function automatic logic get_done(input bit who);
    return who ? bus.req1_done : bus.req0_done;
  endfunction

  task automatic drive_req(input bit who, input logic v, input logic [5:0] c,
                           input logic [31:0] p, input logic [1:0] r);
    if (!who) begin
      bus.req0_valid = v; bus.req0_cmd = c; bus.req0_para = p; bus.req0_rsp = r;
    end else begin
      bus.req1_valid = v; bus.req1_cmd = c; bus.req1_para = p; bus.req1_rsp = r;
    end
  endtask

  task automatic clear_inputs();
    drive_req(1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    bus.i_tx_busy = 1'b0; bus.i_rx_de = 1'b0; bus.i_rx_crc7_down = 1'b0;
    bus.i_rx_cmd = '0; bus.i_rx_para = '0; bus.i_rx_cid = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_en"},    bus.o_tx_en, 1'b0);
    chk({tag, "_listen"},   bus.o_rx_listen, 1'b0);
    chk({tag, "_rsp136en"}, bus.o_rx_rsp136en, 1'b0);
    chk({tag, "_ack0"},     bus.req0_ack, 1'b0);
    chk({tag, "_ack1"},     bus.req1_ack, 1'b0);
    chk({tag, "_done0"},    bus.req0_done, 1'b0);
    chk({tag, "_done1"},    bus.req1_done, 1'b0);
    chk({tag, "_busy"},     bus.busy, 1'b0);
    chk({tag, "_status"},   bus.rsp_status, 2'd0);
    chk({tag, "_rsp_cmd"},  bus.rsp_cmd, 6'd0);
    chk({tag, "_rsp_para"}, bus.rsp_para, 32'd0);
    chk({tag, "_rsp_cid"},  bus.rsp_cid, 120'd0);
    chk({tag, "_tx_cmd"},   bus.o_tx_cmd, 6'd0);
    chk({tag, "_tx_para"},  bus.o_tx_para, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge ctrl_clk); #1; n++;
    end
    chk(name, bus.busy, 1'b0);
  endtask

  // One full command from grant to done, checked against hand-derived timing.
  task automatic do_txn(input int idx, input vec_t v);
    int c; int l_cyc; int d_cyc; int exit_c; int exp_d;
    drive_req(v.who, 1'b1, v.cmd, v.para, v.rsp);
    bus.i_tx_busy = (v.busy_cyc > 0);
    bus.i_rx_de = 1'b0; bus.i_rx_crc7_down = v.crc;
    bus.i_rx_cmd = v.rx_cmd; bus.i_rx_para = v.rx_para; bus.i_rx_cid = v.rx_cid;
    #1;
    chk("grant_ack", get_ack(v.who), 1'b1);
    chk("other_ack", get_ack(!v.who), 1'b0);
    chk("busy_in_idle", bus.busy, 1'b0);
    c = 0; l_cyc = -1; d_cyc = -1;
    while (d_cyc < 0 && c < 400) begin
      @(negedge ctrl_clk);
      c++;
      drive_req(v.who, 1'b0, v.cmd, v.para, v.rsp);
      bus.i_tx_busy = (c < v.busy_cyc);
      bus.i_rx_de = 1'b0;
      bus.i_rx_cmd = v.rx_cmd; bus.i_rx_para = v.rx_para; bus.i_rx_cid = v.rx_cid;
      if (c == 5) begin
        // stray response while still in TX_WAIT must be ignored
        bus.i_rx_de = 1'b1; bus.i_rx_cmd = 6'h3F; bus.i_rx_para = 32'hDEADBEEF;
        bus.i_rx_cid = {120{1'b1}};
      end
      if (l_cyc >= 0 && v.de_dly >= 0 && c == l_cyc + v.de_dly) bus.i_rx_de = 1'b1;
      #1;
      if (c == 1) begin
        chk("tx_en_issue", bus.o_tx_en, 1'b1);
        chk("tx_cmd", bus.o_tx_cmd, v.cmd);
        chk("tx_para", bus.o_tx_para, v.para);
        chk("busy_issue", bus.busy, 1'b1);
      end
      if (c == 2) begin
        chk("tx_en_one_cycle", bus.o_tx_en, 1'b0);
        chk("tx_cmd_hold", bus.o_tx_cmd, v.cmd);
      end
      if (l_cyc < 0 && bus.o_rx_listen) begin
        l_cyc = c;
        chk("rsp136en_listen", bus.o_rx_rsp136en, (v.rsp == 2'd2));
      end
      if (bus.req0_done || bus.req1_done) d_cyc = c;
    end
    if (d_cyc < 0) begin
      checks++; errors++;
      $display("FAIL done_seen txn=%0d actual=none required=done within 400 cycles", idx);
      return;
    end
    exit_c = (v.busy_cyc > TS + 2) ? v.busy_cyc : TS + 2;
    if (v.rsp == 2'd0) begin
      exp_d = exit_c + 1;
    end else begin
      chk("listen_rise", l_cyc, exit_c + 1);
      exp_d = (v.de_dly >= 0) ? l_cyc + v.de_dly + 1 : l_cyc + RT + 1;
    end
    if (v.rsp != 2'd0 && v.de_dly >= 0) begin
      m_rsp_cmd = v.rx_cmd; m_rsp_para = v.rx_para; m_rsp_cid = v.rx_cid;
    end
    chk("done_latency", d_cyc, exp_d);
    chk("done_own", get_done(v.who), 1'b1);
    chk("done_other", get_done(!v.who), 1'b0);
    chk("status", bus.rsp_status, v.exp_status);
    chk("listen_drop", bus.o_rx_listen, 1'b0);
    chk("rsp136en_drop", bus.o_rx_rsp136en, 1'b0);
    chk("busy_done", bus.busy, 1'b1);
    chk("rsp_cmd", bus.rsp_cmd, m_rsp_cmd);
    chk("rsp_para", bus.rsp_para, m_rsp_para);
    chk("rsp_cid", bus.rsp_cid, m_rsp_cid);
    @(negedge ctrl_clk); #1;
    chk("done_pulse", get_done(v.who), 1'b0);
    chk("busy_after", bus.busy, 1'b0);
    chk("status_hold", bus.rsp_status, v.exp_status);
    $display("txn %0d req%0d cmd=%0d rsp=%0d status=%0d done_cycle=%0d listen_cycle=%0d",
             idx, v.who, v.cmd, v.rsp, bus.rsp_status, d_cyc, l_cyc);
  endtask

  // Both requesters held valid from reset: grants must go 0,1,0 back to back.
  task automatic round_robin();
    int c = 0; int n = 0; int d0 = 0; int d1 = 0; int ntx = 0;
    int who_q[3]; int cyc_q[3];
    for (int i = 0; i < 3; i++) begin who_q[i] = -1; cyc_q[i] = -100; end
    drive_req(1'b0, 1'b1, 6'd5, 32'h5, 2'd0);
    drive_req(1'b1, 1'b1, 6'd6, 32'h6, 2'd0);
    bus.i_tx_busy = 1'b0;
    while (c < 120) begin
      #1;
      chk("rr_ack_overlap", bus.req0_ack & bus.req1_ack, 1'b0);
      chk("rr_done_overlap", bus.req0_done & bus.req1_done, 1'b0);
      if ((bus.req0_ack || bus.req1_ack) && n < 3) begin
        who_q[n] = int'(bus.req1_ack); cyc_q[n] = c; n++;
        $display("rr grant %0d to req%0d at cycle %0d", n, bus.req1_ack, c);
      end
      if (bus.req0_done) d0++;
      if (bus.req1_done) d1++;
      if (bus.o_tx_en) ntx++;
      if (n == 3 && !bus.busy && c > cyc_q[2]) break;
      @(negedge ctrl_clk); c++;
      if (n >= 3) begin
        drive_req(1'b0, 1'b0, 6'd5, 32'h5, 2'd0);
        drive_req(1'b1, 1'b0, 6'd6, 32'h6, 2'd0);
      end
    end
    chk("rr_grants", n, 3);
    chk("rr_first", who_q[0], 0);
    chk("rr_second", who_q[1], 1);
    chk("rr_third", who_q[2], 0);
    chk("rr_gap1", cyc_q[1] - cyc_q[0], TS + 4);
    chk("rr_gap2", cyc_q[2] - cyc_q[1], TS + 4);
    chk("rr_tx_pulses", ntx, 3);
    chk("rr_done0", d0, 2);
    chk("rr_done1", d1, 1);
  endtask

  // Reset asserted between clock edges while listening for a response.
  task automatic reset_mid_rx();
    int c = 0;
    drive_req(1'b0, 1'b1, 6'd8, 32'h1AA, 2'd1);
    bus.i_tx_busy = 1'b0; bus.i_rx_de = 1'b0;
    #1;
    chk("mid_ack0", bus.req0_ack, 1'b1);
    @(negedge ctrl_clk);
    drive_req(1'b0, 1'b0, 6'd8, 32'h1AA, 2'd1);
    #1;
    while (!bus.o_rx_listen && c < 50) begin
      @(negedge ctrl_clk); #1; c++;
    end
    chk("mid_listen", bus.o_rx_listen, 1'b1);
    repeat (3) @(negedge ctrl_clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge ctrl_clk);
    rst_n = 1'b1;
    m_rsp_cmd = '0; m_rsp_para = '0; m_rsp_cid = '0;
    repeat (5) begin
      @(negedge ctrl_clk); #1;
      chk("post_rst_done0", bus.req0_done, 1'b0);
      chk("post_rst_done1", bus.req1_done, 1'b0);
      chk("post_rst_busy", bus.busy, 1'b0);
    end
    drive_req(1'b0, 1'b1, 6'd0, 32'h0, 2'd0);
    drive_req(1'b1, 1'b1, 6'd0, 32'h0, 2'd0);
    #1;
    chk("post_rst_ack0", bus.req0_ack, 1'b1);
    chk("post_rst_ack1", bus.req1_ack, 1'b0);
    $display("reset during RX_WAIT, next grant ack0=%0d ack1=%0d", bus.req0_ack, bus.req1_ack);
    @(negedge ctrl_clk);
    drive_req(1'b0, 1'b0, 6'd0, 32'h0, 2'd0);
    drive_req(1'b1, 1'b0, 6'd0, 32'h0, 2'd0);
    #1;
    wait_idle("post_rst_idle");
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = mk(1'b0, 6'd0,  32'h0,        2'd0, 0,  -1, 6'd0,  32'h0,        120'h0, 1'b1, 2'd0);
    vecs[1] = mk(1'b0, 6'd8,  32'h1AA,      2'd1, 0,  20, 6'd8,  32'h1AA,      120'h0, 1'b1, 2'd0);
    vecs[2] = mk(1'b1, 6'd8,  32'h1AA,      2'd1, 0,  -1, 6'd8,  32'h1AA,      120'h0, 1'b1, 2'd1);
    vecs[3] = mk(1'b0, 6'd8,  32'h1AA,      2'd1, 0,  RT, 6'd8,  32'h2AA,      120'h0, 1'b1, 2'd0);
    vecs[4] = mk(1'b1, 6'd41, 32'h40FF8000, 2'd1, 0,  7,  6'd55, 32'h00FF8000, 120'h0, 1'b1, 2'd3);
    vecs[5] = mk(1'b0, 6'd41, 32'h40FF8000, 2'd3, 0,  9,  6'd63, 32'h80FF8000, 120'h0, 1'b0, 2'd0);
    vecs[6] = mk(1'b1, 6'd2,  32'h0,        2'd2, 0,  12, 6'd63, 32'h0,
                 120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 1'b0, 2'd2);
    vecs[7] = mk(1'b0, 6'd2,  32'h0,        2'd2, 0,  30, 6'd63, 32'h0,
                 120'hFEDC_BA98_7654_3210_AA55_AA55_AA55_AA, 1'b1, 2'd0);
    vecs[8] = mk(1'b1, 6'd7,  32'h12340000, 2'd0, 18, -1, 6'd0,  32'h0,        120'h0, 1'b1, 2'd0);
    vecs[9] = mk(1'b0, 6'd17, 32'h200,      2'd1, 15, 3,  6'd17, 32'h900,      120'h5, 1'b0, 2'd2);

    clear_inputs();
    repeat (2) @(negedge ctrl_clk);
    bus.req0_valid = 1'b1;
    #1;
    check_outputs_zero("reset");
    bus.req0_valid = 1'b0;
    @(negedge ctrl_clk);
    rst_n = 1'b1;
    @(negedge ctrl_clk);

    round_robin();

    for (int i = 0; i < 10; i++) do_txn(i, vecs[i]);

    reset_mid_rx();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
